aes_job_arbiter: RTL

Single-clock controller that shares one `aes_core` between two on-chip requesters. It grants jobs round-robin and latches the winner's key and plaintext. It sequences the core's `load`/`done` handshake, captures the cyphertext, and returns it to the granted requester with a one-cycle response strobe; a watchdog aborts jobs whose `done` never arrives. It sits between the SPI/host-side logic and `aes_core`, in the `clk` (HSOSC) domain.

---
 rtl/aes_job_arbiter.sv | 209 ++++++++++++++++++++
 1 files changed

// File: rtl/aes_job_arbiter.sv
// -----------------------------------------------------------------------------
// aes_job_arbiter
//
// Shares a single aes_core between two on-chip requesters. Jobs are granted
// round-robin from IDLE, the winner's key/plaintext are latched onto the core
// operand bus, the core's load/done handshake is sequenced, and the
// cyphertext (or an error if the watchdog expires) is returned to the owning
// requester with a one-cycle strobe.
//
// Parameters:
//   LOAD_CYCLES    - cycles core_load is held high per job (>= 1)
//   TIMEOUT_CYCLES - RUN-state cycles without core_done before abort (>= 1)
//
// Ports:
//   clk        in   system clock, all logic on posedge
//   reset_n    in   asynchronous active-low reset
//   req_valid  in   [1:0] per-requester job request, held until req_ack
//   req0_key   in   [127:0] requester 0 key
//   req1_key   in   [127:0] requester 1 key
//   req0_pt    in   [127:0] requester 0 plaintext
//   req1_pt    in   [127:0] requester 1 plaintext
//   req_ack    out  [1:0] one-hot pulse, job accepted and operands latched
//   rsp_valid  out  [1:0] one-hot pulse to the job owner, result present
//   rsp_data   out  [127:0] cyphertext (0 on error), held until next response
//   rsp_err    out  qualifies rsp_valid, 1 = watchdog timeout
//   busy       out  high in LOAD, RUN and RESP
//   core_load  out  aes_core.load
//   core_key   out  [127:0] latched key to the core
//   core_pt    out  [127:0] latched plaintext to the core
//   core_done  in   aes_core.done
//   core_ct    in   [127:0] aes_core.cyphertext
// -----------------------------------------------------------------------------
module aes_job_arbiter #(
  parameter int LOAD_CYCLES    = 2,
  parameter int TIMEOUT_CYCLES = 1023
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic [1:0]   req_valid,
  input  logic [127:0] req0_key,
  input  logic [127:0] req1_key,
  input  logic [127:0] req0_pt,
  input  logic [127:0] req1_pt,
  output logic [1:0]   req_ack,
  output logic [1:0]   rsp_valid,
  output logic [127:0] rsp_data,
  output logic         rsp_err,
  output logic         busy,
  output logic         core_load,
  output logic [127:0] core_key,
  output logic [127:0] core_pt,
  input  logic         core_done,
  input  logic [127:0] core_ct
);

  localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam int LC_W = (LOAD_CYCLES > 1) ? $clog2(LOAD_CYCLES) : 1;

  localparam logic [WD_W-1:0] WD_MAX = WD_W'(TIMEOUT_CYCLES);
  localparam logic [LC_W-1:0] LC_MAX = LC_W'(LOAD_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_RUN,
    S_RESP
  } state_t;

  state_t          state;
  state_t          state_nxt;
  logic [LC_W-1:0] load_cnt;
  logic [LC_W-1:0] load_cnt_nxt;
  logic [WD_W-1:0] wd_cnt;
  logic [WD_W-1:0] wd_cnt_nxt;

  // The job owner doubles as the round-robin pointer: it is written with the
  // winner on every grant, so it is also the last requester served. Reset to
  // 1 so that requester 0 wins the first tie.
  logic            owner;
  logic [1:0]      owner_vec;

  logic            grant;
  logic            winner;
  logic            capture_ok;
  logic            capture_err;

  // On a tie the requester that was not served last wins; otherwise the
  // single active requester wins (bit 1 set alone selects requester 1).
  assign winner    = (req_valid == 2'b11) ? ~owner : req_valid[1];
  assign grant     = (state == S_IDLE) && (req_valid != 2'b00);
  assign owner_vec = owner ? 2'b10 : 2'b01;

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  // NOTE: every signal assigned here gets a default first so no path leaves
  // it unassigned, which would otherwise infer a latch.
  always_comb begin
    state_nxt    = state;
    load_cnt_nxt = load_cnt;
    wd_cnt_nxt   = wd_cnt;
    capture_ok   = 1'b0;
    capture_err  = 1'b0;

    case (state)
      S_IDLE: begin
        if (req_valid != 2'b00) begin
          state_nxt    = S_LOAD;
          load_cnt_nxt = '0;
        end
      end

      S_LOAD: begin
        // core_done is deliberately not looked at here: a done left high by
        // the previous job stays high until this load clears it.
        if (load_cnt == LC_MAX) begin
          state_nxt  = S_RUN;
          wd_cnt_nxt = '0;
        end else begin
          load_cnt_nxt = load_cnt + LC_W'(1);
        end
      end

      S_RUN: begin
        // done is tested first so it wins over a simultaneous timeout.
        if (core_done) begin
          capture_ok = 1'b1;
          state_nxt  = S_RESP;
        end else if (wd_cnt == WD_MAX) begin
          capture_err = 1'b1;
          state_nxt   = S_RESP;
        end else begin
          wd_cnt_nxt = wd_cnt + WD_W'(1);
        end
      end

      S_RESP: begin
        state_nxt = S_IDLE;
      end

      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Control registers
  // ---------------------------------------------------------------------------
  // NOTE: state is updated with non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= S_IDLE;
      load_cnt <= '0;
      wd_cnt   <= '0;
      owner    <= 1'b1;
    end else begin
      state    <= state_nxt;
      load_cnt <= load_cnt_nxt;
      wd_cnt   <= wd_cnt_nxt;
      if (grant) begin
        owner <= winner;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Operand and result registers
  // ---------------------------------------------------------------------------
  // Operands change only on a grant, so the core sees a stable key/plaintext
  // for the whole job and until the next grant. The result is held until it
  // is overwritten by the next job's outcome.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      core_key <= '0;
      core_pt  <= '0;
      rsp_data <= '0;
      rsp_err  <= 1'b0;
    end else begin
      if (grant) begin
        core_key <= winner ? req1_key : req0_key;
        core_pt  <= winner ? req1_pt  : req0_pt;
      end
      if (capture_ok) begin
        rsp_data <= core_ct;
        rsp_err  <= 1'b0;
      end else if (capture_err) begin
        rsp_data <= '0;
        rsp_err  <= 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs decoded from registered state
  // ---------------------------------------------------------------------------
  assign busy      = (state != S_IDLE);
  assign core_load = (state == S_LOAD);
  assign req_ack   = ((state == S_LOAD) && (load_cnt == '0)) ? owner_vec : 2'b00;
  assign rsp_valid = (state == S_RESP) ? owner_vec : 2'b00;

  // Handshake strobes must never address both requesters at once.
  a_ack_onehot : assert property (@(posedge clk) disable iff (!reset_n)
    $onehot0(req_ack));
  a_rsp_onehot : assert property (@(posedge clk) disable iff (!reset_n)
    $onehot0(rsp_valid));

endmodule
